// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: drives the memory-mapped ALU's four register writes per command.
// Optional ALU_SEQ_OPERAND_CACHE_EN skips writes whose value the ALU already holds.
module alu_cmd_sequencer #(
  parameter int ADDR_WIDTH     = 2,
  parameter int DATA_WIDTH     = 8,
  parameter int RESULT_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_a,
  input  logic [DATA_WIDTH-1:0] cmd_b,
  input  logic [2:0]            cmd_op,
  output logic                  bus_enable,
  output logic                  bus_rd_wr,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wr_data,
  input  logic [15:0]           res_in,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [15:0]           rsp_data,
  output logic                  rsp_op_err,
  output logic                  busy
);

  localparam int CW = (RESULT_LATENCY > 1) ? $clog2(RESULT_LATENCY) : 1;
  localparam logic [CW-1:0] LAST = CW'(RESULT_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE, WR_A, WR_B, WR_OP, EXEC, WAIT, RESP
  } state_t;

  state_t state, state_d;
  state_t after_a, after_b, in_after_a, in_after_b, in_first;

  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]            op_q, op_d;
  logic [CW-1:0]         cnt, cnt_d;

  logic                  bus_enable_d;
  logic [ADDR_WIDTH-1:0] bus_addr_d;
  logic [DATA_WIDTH-1:0] bus_wr_data_d;
  logic                  rsp_valid_d;
  logic [15:0]           rsp_data_d;
  logic                  rsp_op_err_d;

  logic accept;
  logic skip_b, skip_op;
  logic in_skip_a, in_skip_b, in_skip_op;

  assign accept    = cmd_valid && cmd_ready;
  assign bus_rd_wr = 1'b0;

`ifdef ALU_SEQ_OPERAND_CACHE_EN
  logic [DATA_WIDTH-1:0] ca_q, ca_d, cb_q, cb_d;
  logic [2:0]            cop_q, cop_d;
  logic                  cv_q, cv_d;

  assign in_skip_a  = cv_q && (cmd_a == ca_q);
  assign in_skip_b  = cv_q && (cmd_b == cb_q);
  assign in_skip_op = cv_q && (cmd_op == cop_q);
  assign skip_b     = cv_q && (b_q == cb_q);
  assign skip_op    = cv_q && (op_q == cop_q);
`else
  assign in_skip_a  = 1'b0;
  assign in_skip_b  = 1'b0;
  assign in_skip_op = 1'b0;
  assign skip_b     = 1'b0;
  assign skip_op    = 1'b0;
`endif

  // Skipped writes collapse into the same cycle, so chains resolve combinationally
  assign after_b    = skip_op ? EXEC : WR_OP;
  assign after_a    = skip_b ? after_b : WR_B;
  assign in_after_b = in_skip_op ? EXEC : WR_OP;
  assign in_after_a = in_skip_b ? in_after_b : WR_B;
  assign in_first   = in_skip_a ? in_after_a : WR_A;

  always_comb begin
    state_d       = state;
    a_d           = a_q;
    b_d           = b_q;
    op_d          = op_q;
    cnt_d         = cnt;
    bus_enable_d  = 1'b0;
    bus_addr_d    = '0;
    bus_wr_data_d = '0;
    rsp_valid_d   = 1'b0;
    rsp_data_d    = rsp_data;
    rsp_op_err_d  = rsp_op_err;
`ifdef ALU_SEQ_OPERAND_CACHE_EN
    ca_d          = ca_q;
    cb_d          = cb_q;
    cop_d         = cop_q;
    cv_d          = cv_q;
`endif
    unique case (state)
      IDLE: begin
        if (accept) begin
          a_d     = cmd_a;
          b_d     = cmd_b;
          op_d    = cmd_op;
          state_d = in_first;
        end
      end
      WR_A: begin
        bus_enable_d  = 1'b1;
        bus_addr_d    = ADDR_WIDTH'(0);
        bus_wr_data_d = a_q;
        state_d       = after_a;
`ifdef ALU_SEQ_OPERAND_CACHE_EN
        ca_d          = a_q;
`endif
      end
      WR_B: begin
        bus_enable_d  = 1'b1;
        bus_addr_d    = ADDR_WIDTH'(1);
        bus_wr_data_d = b_q;
        state_d       = after_b;
`ifdef ALU_SEQ_OPERAND_CACHE_EN
        cb_d          = b_q;
`endif
      end
      WR_OP: begin
        bus_enable_d  = 1'b1;
        bus_addr_d    = ADDR_WIDTH'(2);
        bus_wr_data_d = DATA_WIDTH'(op_q);
        state_d       = EXEC;
`ifdef ALU_SEQ_OPERAND_CACHE_EN
        cop_d         = op_q;
`endif
      end
      EXEC: begin
        bus_enable_d  = 1'b1;
        bus_addr_d    = ADDR_WIDTH'(3);
        bus_wr_data_d = DATA_WIDTH'(1);
        cnt_d         = '0;
        state_d       = WAIT;
`ifdef ALU_SEQ_OPERAND_CACHE_EN
        cv_d          = 1'b1;
`endif
      end
      WAIT: begin
        cnt_d = cnt + CW'(1);
        if (cnt == LAST) begin
          rsp_data_d   = res_in;
          rsp_op_err_d = (op_q > 3'd4);
          state_d      = RESP;
        end
      end
      RESP: begin
        if (rsp_valid && rsp_ready) state_d = IDLE;
        else rsp_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      cnt         <= '0;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      bus_enable  <= 1'b0;
      bus_addr    <= '0;
      bus_wr_data <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_op_err  <= 1'b0;
    end else begin
      state       <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      cnt         <= cnt_d;
      cmd_ready   <= (state_d == IDLE);
      busy        <= (state_d != IDLE);
      bus_enable  <= bus_enable_d;
      bus_addr    <= bus_addr_d;
      bus_wr_data <= bus_wr_data_d;
      rsp_valid   <= rsp_valid_d;
      rsp_data    <= rsp_data_d;
      rsp_op_err  <= rsp_op_err_d;
    end
  end

`ifdef ALU_SEQ_OPERAND_CACHE_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ca_q  <= '0;
      cb_q  <= '0;
      cop_q <= '0;
      cv_q  <= 1'b0;
    end else begin
      ca_q  <= ca_d;
      cb_q  <= cb_d;
      cop_q <= cop_d;
      cv_q  <= cv_d;
    end
  end
`endif

endmodule
